// File: rtl/manch_pkg.sv
// manch_pkg: shared state type, ISO 14443-A timing defaults and odd-parity helper
package manch_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_PAR, S_EOF} state_t;
  localparam int ISO_SC_DIV = 8;
  localparam int ISO_SC_PER_HALF = 4;
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/manch_tick_gen.sv
// manch_tick_gen: subcarrier (next-clock level, for registering) plus half-bit and bit end ticks
module manch_tick_gen import manch_pkg::*; #(
  parameter int SC_DIV = ISO_SC_DIV,
  parameter int SC_PER_HALF = ISO_SC_PER_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic sc,
  output logic hb_tick,
  output logic bit_tick
);
  localparam int HB = 2 * SC_DIV * SC_PER_HALF;
  localparam int SW = SC_DIV > 1 ? $clog2(SC_DIV) : 1;
  localparam int HW = $clog2(HB);
  logic [SW-1:0] sc_cnt;
  logic [HW-1:0] hb_cnt;
  logic sc_q, half;
  assign hb_tick = run && hb_cnt == HW'(HB - 1);
  assign bit_tick = hb_tick && half;
  assign sc = start || (run && (sc_cnt == SW'(SC_DIV - 1) ? !sc_q : sc_q));
  always_ff @(posedge clk) begin
    sc_q <= !rst && sc;
    if (rst || start || !run) begin
      sc_cnt <= '0;
      hb_cnt <= '0;
      half <= 1'b0;
    end else begin
      sc_cnt <= sc_cnt == SW'(SC_DIV - 1) ? '0 : sc_cnt + 1'b1;
      hb_cnt <= hb_tick ? '0 : hb_cnt + 1'b1;
      half <= hb_tick ? !half : half;
    end
  end
endmodule

// File: rtl/manch_frame_enc.sv
// manch_frame_enc: ISO 14443-A card-to-reader Manchester frame encoder with SOF, odd parity and EOF
module manch_frame_enc import manch_pkg::*; #(
  parameter int SC_DIV = ISO_SC_DIV,
  parameter int SC_PER_HALF = ISO_SC_PER_HALF,
  parameter int MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       parity_en,
  output logic       busy,
  output logic       underrun,
  output logic       env,
  output logic       out_data
);
  state_t state, state_n;
  logic [7:0] byte_q, byte_n, hold_q, hold_n;
  logic [2:0] idx_q, idx_n;
  logic last_q, last_n, par_en_q, par_en_n, hold_last_q, hold_last_n, hold_v_q, hold_v_n;
  logic sc, hb_tick, bit_tick, accept, win, fin, cur_b, nxt_b, env_n, under_n;
  manch_tick_gen #(.SC_DIV(SC_DIV), .SC_PER_HALF(SC_PER_HALF)) u_tick (
    .clk(clk), .rst(rst), .start(state == S_IDLE && accept), .run(busy),
    .sc(sc), .hb_tick(hb_tick), .bit_tick(bit_tick)
  );
  assign busy = state != S_IDLE;
  assign win = !last_q && (state == S_PAR || (state == S_DATA && idx_q == 3'd7 && !par_en_q));
  assign in_ready = state == S_IDLE || (win && !hold_v_q);
  assign accept = in_valid && in_ready;
  assign fin = bit_tick && win;
  assign cur_b = state == S_SOF || (state == S_DATA && byte_q[idx_q]) || (state == S_PAR && odd_par(byte_q));
  assign nxt_b = state_n == S_SOF || (state_n == S_DATA && byte_n[idx_n]) || (state_n == S_PAR && odd_par(byte_n));
  assign env_n = state == S_IDLE || bit_tick ? nxt_b : hb_tick ? state != S_EOF && !cur_b : env;
  always_comb begin
    state_n = state;
    byte_n = byte_q;
    idx_n = idx_q;
    last_n = last_q;
    par_en_n = par_en_q;
    hold_n = hold_q;
    hold_last_n = hold_last_q;
    hold_v_n = hold_v_q;
    under_n = 1'b0;
    if (state == S_IDLE && accept) begin
      state_n = S_SOF;
      byte_n = in_data;
      idx_n = 3'd0;
      last_n = in_last;
      par_en_n = parity_en;
    end else if (fin && (hold_v_q || accept)) begin
      state_n = S_DATA;
      byte_n = hold_v_q ? hold_q : in_data;
      last_n = hold_v_q ? hold_last_q : in_last;
      idx_n = 3'd0;
      hold_v_n = 1'b0;
    end else if (fin) begin
      state_n = S_EOF;
      under_n = 1'b1;
    end else begin
      if (accept) begin
        hold_n = in_data;
        hold_last_n = in_last;
        hold_v_n = 1'b1;
      end
      if (bit_tick) begin
        state_n = state == S_SOF ? S_DATA :
                  state == S_DATA && idx_q != 3'd7 ? S_DATA :
                  state == S_DATA && par_en_q ? S_PAR :
                  state == S_EOF ? S_IDLE : S_EOF;
        idx_n = state == S_DATA ? idx_q + 3'd1 : 3'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      byte_q <= '0;
      idx_q <= '0;
      last_q <= 1'b0;
      par_en_q <= 1'b0;
      hold_q <= '0;
      hold_last_q <= 1'b0;
      hold_v_q <= 1'b0;
      env <= 1'b0;
      out_data <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      byte_q <= byte_n;
      idx_q <= idx_n;
      last_q <= last_n;
      par_en_q <= par_en_n;
      hold_q <= hold_n;
      hold_last_q <= hold_last_n;
      hold_v_q <= hold_v_n;
      env <= env_n;
      out_data <= MODE != 0 ? env_n && sc : env_n;
      underrun <= under_n;
    end
  end
endmodule

// File: tb/tb_manch_frame_enc.sv
// tb_manch_frame_enc: directed checks of framing, handshake, underrun, reset and subcarrier gating
module tb_manch_frame_enc;
  logic clk = 1'b0, rst = 1'b1;
  logic v1 = 1'b0, l1 = 1'b0, p1 = 1'b0, rdy1, busy1, und1, env1, out1;
  logic v2 = 1'b0, l2 = 1'b0, p2 = 1'b0, rdy2, busy2, und2, env2, out2;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  manch_frame_enc dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_last(l1), .in_ready(rdy1),
    .parity_en(p1), .busy(busy1), .underrun(und1), .env(env1), .out_data(out1)
  );
  manch_frame_enc #(.SC_DIV(2), .SC_PER_HALF(2), .MODE(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_last(l2), .in_ready(rdy2),
    .parity_en(p2), .busy(busy2), .underrun(und2), .env(env2), .out_data(out2)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic watch(input int lim, output int len, output logic [31:0] f, output logic [31:0] s,
                       output int oderr, output int und, output int acc_k, output int und_k);
    int k;
    logic took;
    f = '0; s = '0; oderr = 0; und = 0; acc_k = 0; und_k = 0; k = 1;
    while (busy1 && k <= lim) begin
      if ((k - 1) % 128 == 32) f[(k - 1) / 128] = env1;
      if ((k - 1) % 128 == 96) s[(k - 1) / 128] = env1;
      if (out1 !== (env1 && ((k - 1) / 8) % 2 == 0)) oderr++;
      if (und1) begin
        und++;
        if (und_k == 0) und_k = k;
      end
      took = v1 && rdy1;
      if (took) acc_k = k;
      @(negedge clk);
      if (took) v1 = 1'b0;
      k++;
    end
    len = k - 1;
  endtask
  initial begin
    int len, acc_k, und_k, oderr, und, k;
    logic [31:0] f, s;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(rdy1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_env", 32'(env1), 32'd0);
    check("rst_out", 32'(out1), 32'd0);
    check("rst_underrun", 32'(und1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h00; l1 = 1'b0; p1 = 1'b0;
    @(negedge clk);
    d1 = 8'h55; l1 = 1'b1;
    repeat (1030) @(negedge clk);
    check("held_ready_low", 32'(rdy1), 32'd0);
    v1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_env", 32'(env1), 32'd0);
    check("midrst_out", 32'(out1), 32'd0);
    check("midrst_ready", 32'(rdy1), 32'd1);
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", 32'(busy1), 32'd0);
    v1 = 1'b1; d1 = 8'h26; l1 = 1'b1; p1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; p1 = 1'b0;
    check("b26_busy", 32'(busy1), 32'd1);
    check("b26_env_first", 32'(env1), 32'd1);
    check("b26_out_first", 32'(out1), 32'd1);
    check("b26_ready_sof", 32'(rdy1), 32'd0);
    watch(3000, len, f, s, oderr, und, acc_k, und_k);
    check("b26_len", 32'(len), 32'd1408);
    check("b26_env_h1", f, 32'h04D);
    check("b26_env_h2", s, 32'h3B2);
    check("b26_sc_gate", 32'(oderr), 32'd0);
    check("b26_no_underrun", 32'(und), 32'd0);
    check("b26_idle_ready", 32'(rdy1), 32'd1);
    check("b26_idle_env", 32'(env1), 32'd0);
    v1 = 1'b1; d1 = 8'hFF; l1 = 1'b0; p1 = 1'b0;
    @(negedge clk);
    d1 = 8'h00; l1 = 1'b1;
    check("b2b_env", 32'(env1), 32'd1);
    check("b2b_out", 32'(out1), 32'd1);
    watch(3000, len, f, s, oderr, und, acc_k, und_k);
    check("two_accept_cycle", 32'(acc_k), 32'd1025);
    check("two_len", 32'(len), 32'd2304);
    check("two_env_h1", f, 32'h001FF);
    check("two_env_h2", s, 32'h1FE00);
    check("two_sc_gate", 32'(oderr), 32'd0);
    check("two_no_underrun", 32'(und), 32'd0);
    v1 = 1'b1; d1 = 8'hA5; l1 = 1'b0; p1 = 1'b0;
    @(negedge clk);
    v1 = 1'b0;
    watch(3000, len, f, s, oderr, und, acc_k, und_k);
    check("ur_pulses", 32'(und), 32'd1);
    check("ur_cycle", 32'(und_k), 32'd1153);
    check("ur_len", 32'(len), 32'd1280);
    check("ur_env_h1", f, 32'h14B);
    check("ur_env_h2", s, 32'h0B4);
    check("ur_idle_ready", 32'(rdy1), 32'd1);
    v2 = 1'b1; d2 = 8'h26; l2 = 1'b1; p2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    f = '0; s = '0; oderr = 0; k = 1;
    while (busy2 && k <= 400) begin
      if ((k - 1) % 16 == 4) f[(k - 1) / 16] = env2;
      if ((k - 1) % 16 == 12) s[(k - 1) / 16] = env2;
      if (out2 !== env2) oderr++;
      @(negedge clk);
      k++;
    end
    check("m0_len", 32'(k - 1), 32'd176);
    check("m0_env_h1", f, 32'h04D);
    check("m0_env_h2", s, 32'h3B2);
    check("m0_out_eq_env", 32'(oderr), 32'd0);
    check("m0_underrun", 32'(und2), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
